// File: rtl/slicer_pamm_mon.sv
// PAM-M slicer with registered decision, Gray code, slicer error
// and a windowed mean-square-error monitor for link-quality readout.
module slicer_pamm_mon #(
  parameter int NB       = 18,
  parameter int NBF      = 15,
  parameter int LOG2M    = 2,
  parameter int WIN_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic                   i_clr,
  input  logic signed [NB-1:0]   i_sample,
  output logic                   o_valid,
  output logic signed [NB-1:0]   o_symbol,
  output logic [LOG2M-1:0]       o_index,
  output logic [LOG2M-1:0]       o_gray,
  output logic signed [NB:0]     o_error,
  output logic [2*NB+1:0]        o_mse,
  output logic                   o_mse_valid
);

  localparam int M  = 1 << LOG2M;
  localparam int SW = 2*NB + 2;
  localparam int AW = SW + WIN_LOG2;

  typedef enum logic {IDLE, ACC} st_t;

  // Level k rounded half away from zero; M-1 is odd so ties never occur.
  function automatic logic signed [NB:0] lvl(input int k);
    longint num, den, r;
    num = longint'(2*k - M + 1) * (longint'(1) << NBF);
    den = longint'(M - 1);
    if (num >= 0)
      r = (num + den/2) / den;
    else
      r = -((-num + den/2) / den);
    return (NB+1)'(r);
  endfunction

  function automatic logic signed [NB:0] thr(input int k);
    logic signed [NB:0]   a, b;
    logic signed [NB+1:0] s;
    a = lvl(k);
    b = lvl(k+1);
    s = {a[NB], a} + {b[NB], b};
    return (NB+1)'(s >>> 1);
  endfunction

  logic signed [NB:0]  xs;
  logic signed [NB:0]  lv_sel;
  logic signed [NB:0]  err_c;
  logic [LOG2M-1:0]    idx_c;

  always_comb begin
    xs = {i_sample[NB-1], i_sample};
    idx_c = '0;
    for (int k = 0; k < M-1; k++)
      if (xs >= thr(k))
        idx_c = idx_c + 1'b1;
    lv_sel = lvl(0);
    for (int k = 1; k < M; k++)
      if (int'(idx_c) == k)
        lv_sel = lvl(k);
    err_c = xs - lv_sel;
  end

  logic          v1, w1, s2_v, mv;
  logic [SW-1:0] e_ext;
  logic [SW-1:0] sq;

  assign e_ext = {{(NB+1){o_error[NB]}}, o_error};
  assign o_valid = v1 & i_enable;
  assign o_mse_valid = mv & i_enable;

  // w1/s2_v mark samples still owed to the window; i_clr drops them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1       <= 1'b0;
      w1       <= 1'b0;
      s2_v     <= 1'b0;
      sq       <= '0;
      o_symbol <= '0;
      o_index  <= '0;
      o_gray   <= '0;
      o_error  <= '0;
    end else begin
      if (i_enable) begin
        v1 <= i_valid;
        if (i_valid) begin
          o_symbol <= lv_sel[NB-1:0];
          o_index  <= idx_c;
          o_gray   <= idx_c ^ (idx_c >> 1);
          o_error  <= err_c;
        end
      end
      if (i_clr && !i_enable)
        w1 <= 1'b0;
      else if (i_enable)
        w1 <= i_valid;
      if (i_clr)
        s2_v <= 1'b0;
      else if (i_enable)
        s2_v <= w1;
      if (i_enable && v1)
        sq <= e_ext * e_ext;
    end
  end

  st_t                 st, st_n;
  logic [AW-1:0]       acc, acc_n, sum;
  logic [WIN_LOG2-1:0] cnt, cnt_n;
  logic [SW-1:0]       mse_n;
  logic                mv_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st    <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      o_mse <= '0;
      mv    <= 1'b0;
    end else begin
      st    <= st_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      o_mse <= mse_n;
      mv    <= mv_n;
    end
  end

  always_comb begin
    st_n  = st;
    acc_n = acc;
    cnt_n = cnt;
    mse_n = o_mse;
    mv_n  = mv;
    sum   = acc + {{WIN_LOG2{1'b0}}, sq};
    if (i_clr) begin
      st_n  = IDLE;
      acc_n = '0;
      cnt_n = '0;
      mv_n  = 1'b0;
    end else if (i_enable) begin
      mv_n = 1'b0;
      if (s2_v) begin
        st_n = ACC;
        if (&cnt) begin
          mse_n = SW'(sum >> WIN_LOG2);
          acc_n = '0;
          cnt_n = '0;
          mv_n  = 1'b1;
        end else begin
          acc_n = sum;
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_slicer_pamm_mon.sv
// Bench for slicer_pamm_mon: PAM4, 4-sample MSE window,
// event-level reference model plus hand-computed checkpoints.
module tb_slicer_pamm_mon;

  logic               clk;
  logic               rst;
  logic               i_enable;
  logic               i_valid;
  logic               i_clr;
  logic signed [17:0] i_sample;
  logic               o_valid;
  logic signed [17:0] o_symbol;
  logic [1:0]         o_index;
  logic [1:0]         o_gray;
  logic signed [18:0] o_error;
  logic [37:0]        o_mse;
  logic               o_mse_valid;

  slicer_pamm_mon #(
    .NB(18), .NBF(15), .LOG2M(2), .WIN_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_enable(i_enable), .i_valid(i_valid),
    .i_clr(i_clr), .i_sample(i_sample),
    .o_valid(o_valid), .o_symbol(o_symbol),
    .o_index(o_index), .o_gray(o_gray),
    .o_error(o_error), .o_mse(o_mse),
    .o_mse_valid(o_mse_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference: PAM4 levels/thresholds, decisions by threshold count
  localparam int LV[4] = '{-32768, -10923, 10923, 32768};
  localparam int TH[3] = '{-21846, 0, 21845};

  typedef struct {
    longint sym;
    longint idx;
    longint gray;
    longint err;
  } dec_t;

  typedef struct {
    longint sq;
    int     age;
  } fl_t;

  function automatic dec_t decide(input int x);
    dec_t d;
    int   n;
    n = 0;
    for (int k = 0; k < 3; k++)
      if (x >= TH[k]) n++;
    d.idx  = n;
    d.gray = n ^ (n >> 1);
    d.sym  = LV[n];
    d.err  = x - LV[n];
    return d;
  endfunction

  dec_t   last;
  bit     pend;
  fl_t    fl[$];
  longint wsum;
  int     wcnt;
  longint m_mse;
  bit     m_pv;

  // Model update: each accepted sample reaches the window two
  // enabled edges after its decision edge; a clear drops anything
  // accepted earlier that has not yet been added.
  always @(posedge clk) begin
    if (!rst) begin
      last  = '{0, 0, 0, 0};
      pend  = 0;
      fl.delete();
      wsum  = 0;
      wcnt  = 0;
      m_mse = 0;
      m_pv  = 0;
    end else begin
      if (i_enable) pend = 0;
      if (i_clr) begin
        fl.delete();
        wsum = 0;
        wcnt = 0;
        m_pv = 0;
      end else if (i_enable) begin
        m_pv = 0;
        if (fl.size() > 0 && fl[0].age == 1) begin
          wsum += fl[0].sq;
          wcnt++;
          void'(fl.pop_front());
          if (wcnt == 4) begin
            m_mse = wsum / 4;
            m_pv  = 1;
            wsum  = 0;
            wcnt  = 0;
          end
        end
        foreach (fl[i]) fl[i].age++;
      end
      if (i_enable && i_valid) begin
        dec_t d;
        fl_t  f;
        d     = decide(int'(i_sample));
        last  = d;
        pend  = 1;
        f.sq  = d.err * d.err;
        f.age = 0;
        fl.push_back(f);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("o_valid", o_valid, pend && i_enable);
      chk("o_symbol", o_symbol, last.sym);
      chk("o_index", o_index, last.idx);
      chk("o_gray", o_gray, last.gray);
      chk("o_error", o_error, last.err);
      chk("o_mse", o_mse, m_mse);
      chk("o_mse_valid", o_mse_valid, m_pv && i_enable);
    end
  end

  task automatic step(input logic en, input logic v,
                      input logic c, input int x);
    i_enable = en;
    i_valid  = v;
    i_clr    = c;
    i_sample = x[17:0];
    @(posedge clk);
    #1;
  endtask

  int t1x[4]   = '{0, 21845, -21846, -131072};
  int t1idx[4] = '{2, 3, 1, 0};
  int t1gr[4]  = '{3, 2, 1, 0};
  int t1sym[4] = '{10923, 32768, -10923, -32768};
  int t1err[4] = '{-10923, -10923, -10923, -98304};
  int s3[4]    = '{30000, -5000, 12000, -32000};
  localparam longint MSE3 = 11123376;

  initial begin
    rst = 1'b0;
    i_enable = 1'b0;
    i_valid = 1'b0;
    i_clr = 1'b0;
    i_sample = '0;
    step(1, 1, 0, 5000);
    step(1, 1, 0, 5000);
    chk_on = 1;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_mse", o_mse, 0);
    rst = 1'b1;

    // decisions
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, t1x[i]);
      @(negedge clk);
      chk("t1_valid", o_valid, 1);
      chk("t1_idx", o_index, t1idx[i]);
      chk("t1_gray", o_gray, t1gr[i]);
      chk("t1_sym", o_symbol, t1sym[i]);
      chk("t1_err", o_error, t1err[i]);
    end

    // back-to-back windows
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, (i < 4) ? 33792 : 34816);
      @(negedge clk);
      if (i == 5) begin
        chk("t2_pulse1", o_mse_valid, 1);
        chk("t2_mse1", o_mse, 1048576);
      end
      if (i == 4 || i == 6)
        chk("t2_nopulse", o_mse_valid, 0);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t2_pulse2", o_mse_valid, 1);
    chk("t2_mse2", o_mse, 4194304);

    // valid toggling
    for (int k = 0; k < 8; k++) begin
      step(1, (k % 2) == 0, 0, s3[k/2]);
      @(negedge clk);
      chk("t3_valid", o_valid, (k % 2) == 0);
    end
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t3_pulse", o_mse_valid, 1);
    chk("t3_mse", o_mse, MSE3);

    // enable gap
    step(1, 1, 0, s3[0]);
    step(1, 1, 0, s3[1]);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 99999);
      @(negedge clk);
      chk("t4_valid_off", o_valid, 0);
      chk("t4_sym_hold", o_symbol, -10923);
    end
    step(1, 1, 0, s3[2]);
    step(1, 1, 0, s3[3]);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t4_pulse", o_mse_valid, 1);
    chk("t4_mse", o_mse, MSE3);

    // clear mid-window
    for (int k = 0; k < 3; k++) step(1, 1, 0, 34816);
    step(1, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, k < 4, 0, 33792);
      @(negedge clk);
      if (k < 5) begin
        chk("t5_nopulse", o_mse_valid, 0);
        chk("t5_mse_hold", o_mse, MSE3);
      end else begin
        chk("t5_pulse", o_mse_valid, 1);
        chk("t5_mse", o_mse, 1048576);
      end
    end

    // reset mid-window
    step(1, 1, 0, 34816);
    step(1, 1, 0, 34816);
    rst = 1'b0;
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t6_valid", o_valid, 0);
    chk("t6_sym", o_symbol, 0);
    chk("t6_idx", o_index, 0);
    chk("t6_gray", o_gray, 0);
    chk("t6_err", o_error, 0);
    chk("t6_mse", o_mse, 0);
    chk("t6_mse_valid", o_mse_valid, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 1, 0, s3[k]);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t6_nopulse", o_mse_valid, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("t6_pulse", o_mse_valid, 1);
    chk("t6_mse_new", o_mse, MSE3);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
